cook_timer_ctrl: RTL and testbench
==================================

// Module: cook_timer_ctrl
// PURPOSE
//   Central sequencer of the microwave: captures digits from the keyboard/clock front end (D, loadn),
//   holds a 4-digit BCD MM:SS setpoint, counts it down on each p_1hz tick while cooking, and gates the
//   magnetron on door, start, stop and clear. Drives enablen back to the front end to select entry vs. cook timing.
//   Sits between entrada_clock_nivel2 and the 7-segment/magnetron outputs.
// PARAMETERS
//   DONE_TICKS  3  number of p_1hz ticks alarm stays high in DONE before auto-return to IDLE (1..15)
// PORTS
//   clk          in   1  system clock; all inputs synchronous to it
//   resetn       in   1  asynchronous, active-low reset
//   D            in   4  encoded key digit (valid 0..9; 10..15 ignored)
//   loadn        in   1  low while a key is held; falling edge = one digit strobe
//   p_1hz        in   1  1 Hz timing signal; rising edge = one tick
//   startn       in   1  start button, active low; falling edge = press
//   stopn        in   1  stop/pause button, active low; falling edge = press
//   clearn       in   1  clear button, active low; falling edge = press
//   door_closed  in   1  1 = door closed (level)
//   enablen      out  1  1 in IDLE/SET/PAUSE/DONE (keyboard timing), 0 in COOK
//   mag_on       out  1  magnetron enable
//   alarm        out  1  end-of-cook buzzer
//   min_t,min_u  out  4  BCD minutes tens/units
//   sec_t,sec_u  out  4  BCD seconds tens/units
//   state_o      out  3  IDLE=0 SET=1 COOK=2 PAUSE=3 DONE=4
// BEHAVIOUR
//   Reset (async, resetn=0): state IDLE, all digits 0, mag_on 0, alarm 0, enablen 1, edge regs cleared
//     (loadn/startn/stopn/clearn regs = 1, p_1hz reg = 0) so no spurious edge on release.
//   Edge detect: one register per input; event = single-cycle pulse the cycle after the edge is sampled.
//   Event priority per cycle: clear > door-open > stop > start > digit > tick.
//   Digit (IDLE/SET only, D<=9): shift left {min_t,min_u,sec_t,sec_u} <= {min_u,sec_t,sec_u,D};
//     IDLE->SET. D>9 ignored (no shift, no transition). Digits ignored in COOK/PAUSE/DONE.
//   Start: SET/PAUSE -> COOK iff door_closed=1 and time!=00:00; otherwise ignored.
//   Stop: COOK->PAUSE (time held); PAUSE or SET -> IDLE with time cleared; ignored in IDLE.
//   Clear: any state -> IDLE, time 00:00, alarm 0.
//   Door open (door_closed=0) in COOK -> PAUSE next cycle; mag_on gated combinationally:
//     mag_on = (state==COOK) & door_closed, so magnetron drops in the same cycle the door opens.
//   Tick in COOK: BCD decrement; sec_u 0->9 borrow sec_t; sec_t:sec_u 00 -> 59 borrow min_u;
//     min_u 0->9 borrow min_t. Entered seconds 60..99 count down as is (0:90 = 90 ticks).
//     If result is 00:00 -> DONE same edge; time stays 00:00.
//   DONE: alarm=1; tick counter counts DONE_TICKS ticks then -> IDLE, alarm 0.
//     Any digit, start, stop or clear event in DONE -> IDLE immediately (digit not captured).
//   Ticks outside COOK/DONE ignored; simultaneous tick+stop in COOK: stop wins, no decrement.
//   Max setpoint 99:99; no wrap below 00:00.
//   Latency: button/key edge -> state/digit update 2 clk after the input edge (sample + register).
// TESTING
//   Keys 1,3,0 (loadn pulses) -> min=0 1, sec=3 0, state SET; then D=12 strobe -> no change.
//   01:30 + start (door closed) -> COOK, enablen 0, mag_on 1; 1 tick -> 01:29; 31 ticks -> 00:59.
//   00:02 cooking, 2 ticks -> 00:00, DONE, alarm 1 for 3 ticks, then IDLE, alarm 0.
//   COOK, door_closed=0 -> mag_on 0 same cycle, PAUSE; start with door open ignored; close+start -> COOK.
//   COOK stop -> PAUSE time held; stop again -> IDLE 00:00; start at 00:00 ignored (stays IDLE).
//   resetn low mid-COOK at 00:45 -> immediate IDLE, 00:00, mag_on 0; clear+start same cycle -> IDLE.

Source files
------------

// File: rtl/cook_timer_ctrl.sv
// Microwave cook timer sequencer: keypad entry, MM:SS BCD countdown,
// door/start/stop/clear gating of the magnetron and end-of-cook alarm.
//
// Ports:
//   clk, resetn        clock, async active-low reset
//   D, loadn           key digit and strobe (falling edge = digit)
//   p_1hz              1 Hz tick (rising edge)
//   startn/stopn/clearn buttons, active low (falling edge = press)
//   door_closed        door level, 1 = closed
//   enablen            0 only while cooking (front-end timing select)
//   mag_on, alarm      magnetron enable, end-of-cook buzzer
//   min_t..sec_u       BCD MM:SS display digits
//   state_o            IDLE=0 SET=1 COOK=2 PAUSE=3 DONE=4
module cook_timer_ctrl #(
  parameter int unsigned DONE_TICKS = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       p_1hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  output logic       enablen,
  output logic       mag_on,
  output logic       alarm,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic [2:0] state_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SET   = 3'd1;
  localparam logic [2:0] S_COOK  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [3:0] DT_LAST = 4'(DONE_TICKS - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] mt_q, mt_d;
  logic [3:0] mu_q, mu_d;
  logic [3:0] st_q, st_d;
  logic [3:0] su_q, su_d;
  logic [3:0] dcnt_q, dcnt_d;

  // two-stage edge pipes: [0] = sample, [1] = previous sample
  logic [1:0] ld_q;
  logic [1:0] hz_q;
  logic [1:0] sta_q;
  logic [1:0] stp_q;
  logic [1:0] clr_q;
  logic [3:0] d_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ld_q  <= 2'b11;
      hz_q  <= 2'b00;
      sta_q <= 2'b11;
      stp_q <= 2'b11;
      clr_q <= 2'b11;
      d_q   <= 4'd0;
    end else begin
      ld_q  <= {ld_q[0], loadn};
      hz_q  <= {hz_q[0], p_1hz};
      sta_q <= {sta_q[0], startn};
      stp_q <= {stp_q[0], stopn};
      clr_q <= {clr_q[0], clearn};
      d_q   <= D;
    end
  end

  logic dig_ev, tick_ev, start_ev, stop_ev, clr_ev;
  logic dig_ok;

  assign dig_ev   = ld_q[1] & ~ld_q[0];
  assign tick_ev  = ~hz_q[1] & hz_q[0];
  assign start_ev = sta_q[1] & ~sta_q[0];
  assign stop_ev  = stp_q[1] & ~stp_q[0];
  assign clr_ev   = clr_q[1] & ~clr_q[0];
  assign dig_ok   = dig_ev & (d_q <= 4'd9);

  logic in_idle, in_set, in_cook, in_pause, in_done;

  assign in_idle  = (state_q == S_IDLE);
  assign in_set   = (state_q == S_SET);
  assign in_cook  = (state_q == S_COOK);
  assign in_pause = (state_q == S_PAUSE);
  assign in_done  = (state_q == S_DONE);

  logic nz;
  assign nz = |{mt_q, mu_q, st_q, su_q};

  // BCD countdown of the current time by one second
  logic [3:0] dmt, dmu, dst, dsu;
  logic       dzero;

  always_comb begin
    dmt = mt_q;
    dmu = mu_q;
    dst = st_q;
    dsu = su_q;
    if (!nz) begin
      dsu = su_q;
    end else if (su_q != 4'd0) begin
      dsu = su_q - 4'd1;
    end else if (st_q != 4'd0) begin
      dsu = 4'd9;
      dst = st_q - 4'd1;
    end else begin
      dsu = 4'd9;
      dst = 4'd5;
      if (mu_q != 4'd0) begin
        dmu = mu_q - 4'd1;
      end else begin
        dmu = 4'd9;
        dmt = mt_q - 4'd1;
      end
    end
  end

  assign dzero = ~|{dmt, dmu, dst, dsu};

  // only events that act in the current state take priority,
  // so an ignored button never masks a lower event
  logic door_act, stop_act, start_act, done_exit;

  assign door_act  = in_cook & ~door_closed;
  assign stop_act  = stop_ev & ~in_idle;
  assign start_act = start_ev & (in_set | in_pause)
                   & door_closed & nz;
  assign done_exit = in_done & (start_ev | dig_ok);

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mu_d    = mu_q;
    st_d    = st_q;
    su_d    = su_q;
    dcnt_d  = dcnt_q;
    if (clr_ev) begin
      state_d = S_IDLE;
      {mt_d, mu_d, st_d, su_d} = 16'd0;
      dcnt_d  = 4'd0;
    end else if (door_act) begin
      state_d = S_PAUSE;
    end else if (stop_act) begin
      if (in_cook) begin
        state_d = S_PAUSE;
      end else begin
        state_d = S_IDLE;
        {mt_d, mu_d, st_d, su_d} = 16'd0;
        dcnt_d  = 4'd0;
      end
    end else if (start_act) begin
      state_d = S_COOK;
    end else if (done_exit) begin
      state_d = S_IDLE;
      dcnt_d  = 4'd0;
    end else if (dig_ok & (in_idle | in_set)) begin
      state_d = S_SET;
      mt_d    = mu_q;
      mu_d    = st_q;
      st_d    = su_q;
      su_d    = d_q;
    end else if (tick_ev & in_cook) begin
      mt_d = dmt;
      mu_d = dmu;
      st_d = dst;
      su_d = dsu;
      if (dzero) begin
        state_d = S_DONE;
        dcnt_d  = 4'd0;
      end
    end else if (tick_ev & in_done) begin
      if (dcnt_q == DT_LAST) begin
        state_d = S_IDLE;
        dcnt_d  = 4'd0;
      end else begin
        dcnt_d  = dcnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      mt_q    <= 4'd0;
      mu_q    <= 4'd0;
      st_q    <= 4'd0;
      su_q    <= 4'd0;
      dcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      mt_q    <= mt_d;
      mu_q    <= mu_d;
      st_q    <= st_d;
      su_q    <= su_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // magnetron drops in the same cycle the door opens
  assign mag_on  = in_cook & door_closed;
  assign enablen = ~in_cook;
  assign alarm   = in_done;
  assign min_t   = mt_q;
  assign min_u   = mu_q;
  assign sec_t   = st_q;
  assign sec_u   = su_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Bench for cook_timer_ctrl: directed scenarios plus random
// event sequences checked against a transaction-level model.
module tb_cook_timer_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] D = 4'd0;
  logic       loadn = 1'b1;
  logic       p_1hz = 1'b0;
  logic       startn = 1'b1;
  logic       stopn = 1'b1;
  logic       clearn = 1'b1;
  logic       door_closed = 1'b1;
  logic       enablen, mag_on, alarm;
  logic [3:0] min_t, min_u, sec_t, sec_u;
  logic [2:0] state_o;

  cook_timer_ctrl #(.DONE_TICKS(3)) dut (
    .clk(clk), .resetn(resetn), .D(D),
    .loadn(loadn), .p_1hz(p_1hz),
    .startn(startn), .stopn(stopn),
    .clearn(clearn), .door_closed(door_closed),
    .enablen(enablen), .mag_on(mag_on),
    .alarm(alarm), .min_t(min_t),
    .min_u(min_u), .sec_t(sec_t),
    .sec_u(sec_u), .state_o(state_o)
  );

  always #5 clk = ~clk;

  localparam int IDLE = 0;
  localparam int SETS = 1;
  localparam int COOK = 2;
  localparam int PAUS = 3;
  localparam int DONE = 4;
  localparam int DT   = 3;

  int n_checks = 0;
  int n_fail = 0;

  // model: state, setpoint as decimal MMSS, done tick count
  int mst = IDLE;
  int mv = 0;
  int mdc = 0;

  wire [21:0] obs = {state_o, min_t, min_u, sec_t, sec_u,
                     enablen, mag_on, alarm};

  function automatic logic [21:0] exp_vec();
    int mm, ss;
    mm = mv / 100;
    ss = mv % 100;
    return {3'(mst), 4'(mm / 10), 4'(mm % 10),
            4'(ss / 10), 4'(ss % 10),
            (mst != COOK), (mst == COOK && door_closed),
            (mst == DONE)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_reset();
    mst = IDLE; mv = 0; mdc = 0;
  endtask

  task automatic m_digit(input int d);
    if (d > 9) return;
    if (mst == IDLE || mst == SETS) begin
      mv = (mv * 10 + d) % 10000;
      mst = SETS;
    end else if (mst == DONE) begin
      mst = IDLE;
    end
  endtask

  task automatic m_start();
    if ((mst == SETS || mst == PAUS) && door_closed && mv != 0)
      mst = COOK;
    else if (mst == DONE)
      mst = IDLE;
  endtask

  task automatic m_stop();
    if (mst == COOK) mst = PAUS;
    else if (mst != IDLE) begin
      mst = IDLE; mv = 0;
    end
  endtask

  task automatic m_tick();
    int mm, ss;
    if (mst == COOK) begin
      mm = mv / 100;
      ss = mv % 100;
      if (ss > 0) ss--;
      else begin ss = 59; mm--; end
      mv = mm * 100 + ss;
      if (mv == 0) begin mst = DONE; mdc = 0; end
    end else if (mst == DONE) begin
      mdc++;
      if (mdc >= DT) mst = IDLE;
    end
  endtask

  task automatic do_key(input int d);
    D = 4'(d); loadn = 1'b0; cyc(3);
    loadn = 1'b1; cyc(3);
    m_digit(d);
  endtask

  task automatic do_start();
    startn = 1'b0; cyc(3); startn = 1'b1; cyc(3);
    m_start();
  endtask

  task automatic do_stop();
    stopn = 1'b0; cyc(3); stopn = 1'b1; cyc(3);
    m_stop();
  endtask

  task automatic do_clear();
    clearn = 1'b0; cyc(3); clearn = 1'b1; cyc(3);
    m_reset();
  endtask

  task automatic do_tick();
    p_1hz = 1'b1; cyc(3); p_1hz = 1'b0; cyc(3);
    m_tick();
  endtask

  task automatic do_door(input bit c);
    door_closed = c; cyc(3);
    if (!c && mst == COOK) mst = PAUS;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cyc(3);
    m_reset();
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_hold got=%h exp=%h", obs, exp_vec());
    end
    resetn = 1'b1;
    cyc(4);
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_release got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_entry();
    // latency: state unchanged 1 clk after edge, updated after 2
    D = 4'd1; loadn = 1'b0;
    cyc(1);
    n_checks++;
    if (state_o !== 3'(IDLE) || sec_u !== 4'd0) begin
      n_fail++;
      $display("FAIL latency_1clk got st=%0d su=%0d exp st=0 su=0",
               state_o, sec_u);
    end
    cyc(1);
    m_digit(1);
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL latency_2clk got=%h exp=%h", obs, exp_vec());
    end
    loadn = 1'b1; cyc(3);
    do_key(3);
    do_key(0);
    n_checks++;
    if (obs !== exp_vec() || mv != 130) begin
      n_fail++;
      $display("FAIL entry_0130 got=%h exp=%h", obs, exp_vec());
    end
    do_key(12);
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL entry_d12 got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_countdown();
    do_start();
    n_checks++;
    if (obs !== exp_vec() || enablen !== 1'b0 || mag_on !== 1'b1) begin
      n_fail++;
      $display("FAIL cook_start got=%h exp=%h", obs, exp_vec());
    end
    do_tick();
    n_checks++;
    if (obs !== exp_vec() || mv != 129) begin
      n_fail++;
      $display("FAIL tick_0129 got=%h exp=%h", obs, exp_vec());
    end
    repeat (30) do_tick();
    n_checks++;
    if (obs !== exp_vec() || mv != 59) begin
      n_fail++;
      $display("FAIL tick_0059 got=%h exp=%h", obs, exp_vec());
    end
    do_clear();
    // 0:90 counts 90 seconds as entered
    do_key(9); do_key(0); do_start();
    repeat (89) do_tick();
    n_checks++;
    if (obs !== exp_vec() || mv != 1) begin
      n_fail++;
      $display("FAIL tick_0090_89 got=%h exp=%h", obs, exp_vec());
    end
    do_tick();
    n_checks++;
    if (obs !== exp_vec() || mst != DONE) begin
      n_fail++;
      $display("FAIL tick_0090_done got=%h exp=%h", obs, exp_vec());
    end
    do_clear();
  endtask

  task automatic test_done();
    do_key(0); do_key(2); do_start();
    do_tick(); do_tick();
    n_checks++;
    if (obs !== exp_vec() || alarm !== 1'b1 || mst != DONE) begin
      n_fail++;
      $display("FAIL done_enter got=%h exp=%h", obs, exp_vec());
    end
    for (int i = 0; i < DT; i++) begin
      do_tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL done_tick%0d got=%h exp=%h",
                 i, obs, exp_vec());
      end
    end
    n_checks++;
    if (alarm !== 1'b0 || state_o !== 3'(IDLE)) begin
      n_fail++;
      $display("FAIL done_exit got al=%b st=%0d exp al=0 st=0",
               alarm, state_o);
    end
  endtask

  task automatic test_door();
    do_key(5); do_start();
    @(negedge clk);
    door_closed = 1'b0;
    #1;
    n_checks++;
    if (mag_on !== 1'b0 || state_o !== 3'(COOK)) begin
      n_fail++;
      $display("FAIL door_same_cycle got mag=%b st=%0d exp mag=0 st=2",
               mag_on, state_o);
    end
    cyc(3);
    mst = PAUS;
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL door_pause got=%h exp=%h", obs, exp_vec());
    end
    do_start();
    n_checks++;
    if (obs !== exp_vec() || mst != PAUS) begin
      n_fail++;
      $display("FAIL door_open_start got=%h exp=%h", obs, exp_vec());
    end
    do_door(1'b1);
    do_start();
    n_checks++;
    if (obs !== exp_vec() || mst != COOK) begin
      n_fail++;
      $display("FAIL door_resume got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_stop();
    do_tick();
    do_stop();
    n_checks++;
    if (obs !== exp_vec() || mst != PAUS || mv != 4) begin
      n_fail++;
      $display("FAIL stop_pause got=%h exp=%h", obs, exp_vec());
    end
    do_tick();
    do_stop();
    n_checks++;
    if (obs !== exp_vec() || mv != 0) begin
      n_fail++;
      $display("FAIL stop_idle got=%h exp=%h", obs, exp_vec());
    end
    do_start();
    n_checks++;
    if (obs !== exp_vec() || mst != IDLE) begin
      n_fail++;
      $display("FAIL start_zero got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    // reset mid-cook at 00:45
    do_key(4); do_key(5); do_start();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    m_reset();
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_mid_cook got=%h exp=%h", obs, exp_vec());
    end
    cyc(2);
    resetn = 1'b1;
    cyc(3);
    // clear and start pressed together: clear wins
    do_key(3);
    clearn = 1'b0; startn = 1'b0;
    cyc(3);
    clearn = 1'b1; startn = 1'b1;
    cyc(3);
    m_reset();
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL clear_start got=%h exp=%h", obs, exp_vec());
    end
    // valid digit in DONE returns to IDLE without capture
    do_key(1); do_start(); do_tick();
    do_key(7);
    n_checks++;
    if (obs !== exp_vec() || mst != IDLE) begin
      n_fail++;
      $display("FAIL done_digit got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    int r, d;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 30) begin
        d = ($urandom_range(0, 2) != 0) ? $urandom_range(0, 2)
                                        : $urandom_range(3, 9);
        do_key(d);
      end else if (r < 36) do_key($urandom_range(10, 15));
      else if (r < 66) do_tick();
      else if (r < 78) do_start();
      else if (r < 86) do_stop();
      else if (r < 89) do_clear();
      else do_door($urandom_range(0, 3) != 0);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL rand_%0d op=%0d got=%h exp=%h",
                 i, r, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_countdown();
    test_done();
    test_door();
    test_stop();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
